// File: rtl/msg_scroll_led7_if.sv
// Control, write and display bus of the 7-segment message engine.
// master = switch/control side, slave = the display engine.
interface msg_scroll_led7_if #(
  parameter int NUM_DIGITS = 4,
  parameter int AW         = 3
);
  logic                    en;
  logic [1:0]              mode;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [2:0]              wr_code;
  logic [8*NUM_DIGITS-1:0] hex;
  logic [AW-1:0]           pos;
  logic                    tick;

  modport master (
    output en, mode, wr_en, wr_addr, wr_code,
    input  hex, pos, tick
  );

  modport slave (
    input  en, mode, wr_en, wr_addr, wr_code,
    output hex, pos, tick
  );
endinterface

// File: rtl/msg_scroll_led7.sv
// Multi-digit 7-segment message engine: static / scroll left / scroll right / blink.
// All outputs registered; display lags buffer/pos/phase state by one cycle.
module msg_scroll_led7 #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000,
  parameter int AW         = $clog2(MSG_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  msg_scroll_led7_if.slave bus_io
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = 8 * NUM_DIGITS;

  typedef logic [MSG_LEN-1:0][2:0] msg_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  function automatic logic [7:0] seg_decode(input logic [2:0] code);
    logic [7:0] seg;
    case (code)
      3'd0:    seg = 8'h89;
      3'd1:    seg = 8'h86;
      3'd2:    seg = 8'hC7;
      3'd3:    seg = 8'hC7;
      3'd4:    seg = 8'hC0;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  function automatic msg_t msg_reset();
    msg_t m;
    for (int i = 0; i < MSG_LEN; i++) begin
      m[i] = (i < 5) ? 3'(i) : 3'd5;
    end
    return m;
  endfunction

  // Leftmost digit (NUM_DIGITS-1) shows msg[pos]; index wraps as often as needed.
  function automatic logic [HW-1:0] render(input msg_t m, input logic [AW-1:0] p,
                                           input logic ph);
    logic [HW-1:0] r;
    int            idx;
    r = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      idx = (int'(p) + NUM_DIGITS - 1 - d) % MSG_LEN;
      r[8*d +: 8] = ph ? 8'hFF : seg_decode(m[AW'(idx)]);
    end
    return r;
  endfunction

  localparam msg_t          MSG_RST = msg_reset();
  localparam logic [HW-1:0] HEX_RST = render(MSG_RST, '0, 1'b0);

  logic [CW-1:0] cnt_q,   cnt_d;
  logic          tick_q,  tick_d;
  logic [AW-1:0] pos_q,   pos_d;
  logic          phase_q, phase_d;
  msg_t          msg_q,   msg_d;
  logic [HW-1:0] hex_q,   hex_d;
  mode_e         mode;

  assign mode = mode_e'(bus_io.mode);

  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    pos_d   = pos_q;
    phase_d = phase_q;
    msg_d   = msg_q;
    hex_d   = render(msg_q, pos_q, phase_q);

    if (bus_io.en) begin
      tick_d = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    // A tick already issued still moves pos even if en has just dropped.
    if (tick_q) begin
      case (mode)
        MODE_LEFT:  pos_d   = (pos_q == AW'(MSG_LEN - 1)) ? '0 : pos_q + AW'(1);
        MODE_RIGHT: pos_d   = (pos_q == '0) ? AW'(MSG_LEN - 1) : pos_q - AW'(1);
        MODE_BLINK: phase_d = ~phase_q;
        default:    pos_d   = pos_q;
      endcase
    end

    if (mode != MODE_BLINK) begin
      phase_d = 1'b0;
    end

    if (bus_io.wr_en && (int'(bus_io.wr_addr) < MSG_LEN)) begin
      msg_d[bus_io.wr_addr] = bus_io.wr_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      pos_q   <= '0;
      phase_q <= 1'b0;
      msg_q   <= MSG_RST;
      hex_q   <= HEX_RST;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      msg_q   <= msg_d;
      hex_q   <= hex_d;
    end
  end

  assign bus_io.hex  = hex_q;
  assign bus_io.pos  = pos_q;
  assign bus_io.tick = tick_q;

endmodule

// File: tb/tb_msg_scroll_led7.sv
// Bench for msg_scroll_led7 (4 digits, 8 entries, step every 4 cycles):
// directed scenarios plus random traffic against an arithmetic reference model.
module tb_msg_scroll_led7;
  localparam int ND = 4;
  localparam int ML = 8;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;

  msg_scroll_led7_if #(.NUM_DIGITS(ND), .AW(3)) bus ();

  msg_scroll_led7 #(
    .NUM_DIGITS(ND),
    .MSG_LEN   (ML),
    .TICK_DIV  (TD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] seg_tbl [8] = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hFF, 8'hFF};

  // Reference state: counter, pending step, position, blink phase, buffer, shown pattern.
  int          m_cnt, m_pos;
  bit          m_tick, m_phase;
  int          m_msg [ML];
  logic [31:0] m_hex;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] render(input int p, input bit ph);
    logic [31:0] r;
    for (int d = 0; d < ND; d++) begin
      r[8*d +: 8] = ph ? 8'hFF : seg_tbl[m_msg[(p + ND - 1 - d) % ML]];
    end
    return r;
  endfunction

  task automatic model_edge();
    logic [31:0] nh;
    if (rst) begin
      for (int i = 0; i < ML; i++) m_msg[i] = (i < 5) ? i : 5;
      m_cnt = 0; m_tick = 0; m_pos = 0; m_phase = 0;
      m_hex = render(0, 0);
    end else begin
      nh = render(m_pos, m_phase);
      if (m_tick) begin
        if (bus.mode == 2'b01) m_pos = (m_pos + 1) % ML;
        else if (bus.mode == 2'b10) m_pos = (m_pos + ML - 1) % ML;
        else if (bus.mode == 2'b11) m_phase = !m_phase;
      end
      if (bus.mode != 2'b11) m_phase = 0;
      if (bus.en) begin
        m_tick = (m_cnt == TD - 1);
        m_cnt  = (m_cnt + 1) % TD;
      end else begin
        m_tick = 0;
      end
      if (bus.wr_en && int'(bus.wr_addr) < ML) m_msg[bus.wr_addr] = int'(bus.wr_code);
      m_hex = nh;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("hex",  bus.hex, m_hex);
    chk("pos",  32'(bus.pos), 32'(m_pos));
    chk("tick", 32'(bus.tick), 32'(m_tick));
  endtask

  task automatic timeout(input string tag);
    chk(tag, 32'd1, 32'd0);
  endtask

  initial begin
    int          k;
    int          sp;
    logic [31:0] sh;

    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 2'b00;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_code = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_hex", bus.hex, 32'h8986C7C7);
    chk("rst_pos", 32'(bus.pos), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    repeat (5) step();
    chk("idle_hex", bus.hex, 32'h8986C7C7);

    // Scroll left through a full lap.
    bus.en = 1'b1; bus.mode = 2'b01;
    k = 0;
    while (!m_tick && k < 10) begin step(); k++; end
    if (!m_tick) timeout("wait_first_tick");
    step();
    chk("left1_pos", 32'(bus.pos), 32'd1);
    step();
    chk("left1_hex", bus.hex, 32'h86C7C7C0);
    repeat (27) step();
    chk("lap_pos", 32'(bus.pos), 32'd0);
    step();
    chk("lap_hex", bus.hex, 32'h8986C7C7);

    // Blink, then drop back to static while blanked.
    bus.mode = 2'b11;
    k = 0;
    while (!m_phase && k < 20) begin step(); k++; end
    if (!m_phase) timeout("wait_blank");
    bus.mode = 2'b00;
    step();
    chk("blank_hex", bus.hex, 32'hFFFFFFFF);
    step();
    chk("unblank_hex", bus.hex, 32'h8986C7C7);
    chk("unblank_pos", 32'(bus.pos), 32'd0);

    // Static write at pos 2.
    bus.mode = 2'b01;
    k = 0;
    while (m_pos != 2 && k < 20) begin step(); k++; end
    if (m_pos != 2) timeout("wait_pos2");
    bus.mode = 2'b00;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_code = 3'd4;
    step();
    bus.wr_en = 1'b0;
    step();
    chk("wr_static_hex", bus.hex, 32'hC7C7C0C0);

    // Write coinciding with a scroll-left step from pos 4.
    bus.mode = 2'b01;
    k = 0;
    while (!(m_pos == 4 && m_tick) && k < 40) begin step(); k++; end
    if (!(m_pos == 4 && m_tick)) timeout("wait_pos4_tick");
    bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_code = 3'd0;
    step();
    bus.wr_en = 1'b0;
    chk("wr_tick_pos", 32'(bus.pos), 32'd5);
    step();
    chk("wr_tick_hex", bus.hex, 32'hC0FF8989);

    // Freeze while scrolling.
    bus.en = 1'b0;
    step(); step();
    sp = m_pos; sh = m_hex;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("frz_pos", 32'(bus.pos), 32'(sp));
      chk("frz_hex", bus.hex, sh);
      chk("frz_tick", 32'(bus.tick), 32'd0);
    end
    bus.en = 1'b1;

    // Reset mid-scroll, with a write that must be dropped.
    k = 0;
    while (m_pos != 3 && k < 60) begin step(); k++; end
    if (m_pos != 3) timeout("wait_pos3");
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_code = 3'd7;
    step();
    rst = 1'b0; bus.wr_en = 1'b0;
    chk("mid_rst_pos", 32'(bus.pos), 32'd0);
    chk("mid_rst_hex", bus.hex, 32'h8986C7C7);
    repeat (40) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.en      = ($urandom_range(0, 7) != 0);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 3'($urandom_range(0, 7));
      bus.wr_code = 3'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
